sha_round_adder_pipe: RTL

Pipelined, width-parametrised SHA-2 round adder for the compression datapath. Each transaction sums round operands into the new `a`, the new `e` (`o_d` path) and the next message-schedule word. It accepts one transaction per cycle under a valid/ready handshake, tracks the round index per transaction, and supports both SHA-256 (W=32) and SHA-512 (W=64) words.

---
 rtl/sha_round_adder_pipe.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sha_round_adder_pipe.sv
// sha_round_adder_pipe: pipelined SHA-2 round adder.
// Stage 1 reduces the a/e/schedule sums to carry-save pairs.
// Stage 2 resolves the pairs with a carry-propagate add.
// Optional macro SHA_ADDER_PIPE2_EN: when defined, the stage-2 output register
// is present (latency 2). When undefined, the outputs are the combinational
// CPA of stage 1 (latency 1).
module sha_round_adder_pipe #(
  parameter int W      = 32,
  parameter int ROUNDS = 64,
  localparam int RW    = $clog2(ROUNDS)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_start,
  input  logic [W-1:0]    i_kt,
  input  logic [W-1:0]    i_ch,
  input  logic [W-1:0]    i_sum1,
  input  logic [W-1:0]    i_sum0,
  input  logic [W-1:0]    i_sigm1,
  input  logic [W-1:0]    i_sigm0,
  input  logic [W-1:0]    i_maj,
  input  logic [W-1:0]    i_d,
  input  logic [W-1:0]    i_h,
  input  logic [16*W-1:0] i_words,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [W-1:0]    o_a,
  output logic [W-1:0]    o_d,
  output logic [W-1:0]    o_word,
  output logic [RW-1:0]   o_round,
  output logic            o_last
);

  // 3:2 compressor: returns {carry, sum}, carry pre-shifted into weight position
  function automatic logic [2*W-1:0] csa(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic [W-1:0] z);
    logic [W-1:0] maj_bits;
    maj_bits = (x & y) | (x & z) | (y & z);
    return {maj_bits << 1, x ^ y ^ z};
  endfunction

  logic [W-1:0]   w15_s;
  logic [W-1:0]   w6_s;
  logic           unused_words_s;
  logic [2*W-1:0] com_s, dx_s, d1_s, d2_s;
  logic [2*W-1:0] ax_s, a1_s, a2_s, a3_s;
  logic [2*W-1:0] wx_s, w2_s;
  logic [RW-1:0]  tag_s;
  logic [RW-1:0]  rcnt_nxt_s;
  logic           en1_s;
  logic           accept_s;
  logic [W-1:0]   a_sum_s, d_sum_s, w_sum_s;
  logic           last1_s;

  logic           v1_r;
  logic [RW-1:0]  tag1_r;
  logic [RW-1:0]  rcnt_r;
  logic [2*W-1:0] a_pair_r, d_pair_r, w_pair_r;

  assign w15_s          = i_words[15*W +: W];
  assign w6_s           = i_words[6*W +: W];
  assign unused_words_s = ^i_words;

  // Carry-save trees; kt+ch+sum1 is shared between the a and e sums
  always_comb begin
    com_s = csa(i_kt, i_ch, i_sum1);
    dx_s  = csa(w15_s, i_h, i_d);
    d1_s  = csa(com_s[W-1:0], com_s[2*W-1:W], dx_s[W-1:0]);
    d2_s  = csa(d1_s[W-1:0], d1_s[2*W-1:W], dx_s[2*W-1:W]);
    ax_s  = csa(w15_s, i_h, i_maj);
    a1_s  = csa(com_s[W-1:0], com_s[2*W-1:W], ax_s[W-1:0]);
    a2_s  = csa(a1_s[W-1:0], a1_s[2*W-1:W], ax_s[2*W-1:W]);
    a3_s  = csa(a2_s[W-1:0], a2_s[2*W-1:W], i_sum0);
    wx_s  = csa(i_sigm1, w6_s, i_sigm0);
    w2_s  = csa(wx_s[W-1:0], wx_s[2*W-1:W], w15_s);
  end

  // Round tag: start forces 0, otherwise the running counter; next value wraps
  always_comb begin
    if (i_start) begin
      tag_s = {RW{1'b0}};
    end else begin
      tag_s = rcnt_r;
    end
    if (tag_s == RW'(ROUNDS-1)) begin
      rcnt_nxt_s = {RW{1'b0}};
    end else begin
      rcnt_nxt_s = tag_s + RW'(1);
    end
  end

  assign accept_s = i_valid && en1_s;
  assign o_ready  = en1_s;
  assign a_sum_s  = a_pair_r[W-1:0] + a_pair_r[2*W-1:W];
  assign d_sum_s  = d_pair_r[W-1:0] + d_pair_r[2*W-1:W];
  assign w_sum_s  = w_pair_r[W-1:0] + w_pair_r[2*W-1:W];
  assign last1_s  = (tag1_r == RW'(ROUNDS-1));

  // Stage 1: capture carry-save pairs, tag and valid; advance the round counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_r     <= 1'b0;
      tag1_r   <= {RW{1'b0}};
      rcnt_r   <= {RW{1'b0}};
      a_pair_r <= {(2*W){1'b0}};
      d_pair_r <= {(2*W){1'b0}};
      w_pair_r <= {(2*W){1'b0}};
    end else begin
      if (accept_s) begin
        rcnt_r <= rcnt_nxt_s;
      end
      if (en1_s) begin
        v1_r <= i_valid;
        if (i_valid) begin
          tag1_r   <= tag_s;
          a_pair_r <= a3_s;
          d_pair_r <= d2_s;
          w_pair_r <= w2_s;
        end
      end
    end
  end

`ifdef SHA_ADDER_PIPE2_EN
  logic          en2_s;
  logic          v2_r;
  logic          last_out_r;
  logic [RW-1:0] round_out_r;
  logic [W-1:0]  a_out_r, d_out_r, word_out_r;

  assign en2_s = !v2_r || i_ready;
  assign en1_s = !v1_r || en2_s;

  // Stage 2: registered CPA results; holds while the consumer stalls
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v2_r        <= 1'b0;
      last_out_r  <= 1'b0;
      round_out_r <= {RW{1'b0}};
      a_out_r     <= {W{1'b0}};
      d_out_r     <= {W{1'b0}};
      word_out_r  <= {W{1'b0}};
    end else if (en2_s) begin
      v2_r       <= v1_r;
      last_out_r <= v1_r && last1_s;
      if (v1_r) begin
        round_out_r <= tag1_r;
        a_out_r     <= a_sum_s;
        d_out_r     <= d_sum_s;
        word_out_r  <= w_sum_s;
      end
    end
  end

  assign o_valid = v2_r;
  assign o_round = round_out_r;
  assign o_last  = last_out_r;
  assign o_a     = a_out_r;
  assign o_d     = d_out_r;
  assign o_word  = word_out_r;
`else
  assign en1_s   = !v1_r || i_ready;
  assign o_valid = v1_r;
  assign o_round = tag1_r;
  assign o_last  = v1_r && last1_s;
  assign o_a     = a_sum_s;
  assign o_d     = d_sum_s;
  assign o_word  = w_sum_s;
`endif

endmodule
